// File: rtl/ex_mem_if.sv
// Bundle between the decode/issue side and the execute stage, including the
// registered EX->MEM fields consumed by mem_wb and the busy back-pressure.
interface ex_mem_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 5,
    parameter int REG_W = 5
);
    logic               flush;
    logic               in_valid;
    logic [PC_W-1:0]    pc;
    logic [3:0]         alu_op;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   write_data;
    logic [2:0]         jump_type;
    logic               reg_wrenable;
    logic               mem_wrenable;
    logic [REG_W-1:0]   write_reg;
    logic               mem_to_reg;

    logic               busy;
    logic               out_valid;
    logic [PC_W-1:0]    out_pc;
    logic [WIDTH-1:0]   out_alu_res;
    logic [WIDTH-1:0]   out_write_data;
    logic [2:0]         out_jump_type;
    logic               out_reg_wrenable;
    logic               out_mem_wrenable;
    logic [REG_W-1:0]   out_write_reg;
    logic               out_mem_to_reg;

    modport master (
        output flush, in_valid, pc, alu_op, op_a, op_b, write_data, jump_type,
               reg_wrenable, mem_wrenable, write_reg, mem_to_reg,
        input  busy, out_valid, out_pc, out_alu_res, out_write_data, out_jump_type,
               out_reg_wrenable, out_mem_wrenable, out_write_reg, out_mem_to_reg
    );

    modport slave (
        input  flush, in_valid, pc, alu_op, op_a, op_b, write_data, jump_type,
               reg_wrenable, mem_wrenable, write_reg, mem_to_reg,
        output busy, out_valid, out_pc, out_alu_res, out_write_data, out_jump_type,
               out_reg_wrenable, out_mem_wrenable, out_write_reg, out_mem_to_reg
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX->MEM pipeline register.
// state | meaning
// IDLE  | single-cycle ALU ops go straight to the output register
// MUL   | shift-add multiply in flight; output holds bubbles, busy=1
// A MUL result lands WIDTH+1 edges after acceptance: WIDTH accumulate edges,
// then one edge that moves the product into the output register.
module ex_mem_stage #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 5,
    parameter int REG_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_mem_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [WIDTH-1:0]   alu_res;
        logic [WIDTH-1:0]   write_data;
        logic [2:0]         jump_type;
        logic               reg_we;
        logic               mem_we;
        logic [REG_W-1:0]   write_reg;
        logic               mem_to_reg;
    } out_t;

    state_t             state;
    out_t               out_q;
    out_t               in_fields;
    out_t               mul_fields;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic [4:0]         shamt;

    assign shamt = bus.op_b[4:0];

    // Single-cycle ALU; MUL and undefined opcodes produce 0 here.
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            4'd0:    alu_res = bus.op_a + bus.op_b;
            4'd1:    alu_res = bus.op_a - bus.op_b;
            4'd2:    alu_res = bus.op_a & bus.op_b;
            4'd3:    alu_res = bus.op_a | bus.op_b;
            4'd4:    alu_res = bus.op_a ^ bus.op_b;
            4'd5:    alu_res = bus.op_a << shamt;
            4'd6:    alu_res = bus.op_a >> shamt;
            4'd7:    alu_res = WIDTH'($signed(bus.op_a) >>> shamt);
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
            4'd11:   alu_res = bus.op_b;
            default: alu_res = '0;
        endcase
    end

    // Gather the issued instruction into the shape of the output register.
    always_comb begin
        in_fields            = '0;
        in_fields.valid      = 1'b1;
        in_fields.pc         = bus.pc;
        in_fields.alu_res    = alu_res;
        in_fields.write_data = bus.write_data;
        in_fields.jump_type  = bus.jump_type;
        in_fields.reg_we     = bus.reg_wrenable;
        in_fields.mem_we     = bus.mem_wrenable;
        in_fields.write_reg  = bus.write_reg;
        in_fields.mem_to_reg = bus.mem_to_reg;
    end

    // FSM, multiplier datapath and EX->MEM register; all-zero '0 is the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_q      <= '0;
            mul_fields <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        out_q <= '0;
                    end else if (bus.in_valid && bus.alu_op == OP_MUL) begin
                        mul_fields <= in_fields;
                        mcand      <= bus.op_a;
                        mplier     <= bus.op_b;
                        acc        <= '0;
                        count      <= '0;
                        state      <= MUL;
                        out_q      <= '0;
                    end else if (bus.in_valid) begin
                        out_q <= in_fields;
                    end else begin
                        out_q <= '0;
                    end
                end
                MUL: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        out_q <= '0;
                    end else if (count == CNT_W'(WIDTH)) begin
                        out_q         <= mul_fields;
                        out_q.alu_res <= acc;
                        state         <= IDLE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CNT_W'(1);
                        out_q  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    out_q <= '0;
                end
            endcase
        end
    end

    assign bus.busy             = (state == MUL);
    assign bus.out_valid        = out_q.valid;
    assign bus.out_pc           = out_q.pc;
    assign bus.out_alu_res      = out_q.alu_res;
    assign bus.out_write_data   = out_q.write_data;
    assign bus.out_jump_type    = out_q.jump_type;
    assign bus.out_reg_wrenable = out_q.reg_we;
    assign bus.out_mem_wrenable = out_q.mem_we;
    assign bus.out_write_reg    = out_q.write_reg;
    assign bus.out_mem_to_reg   = out_q.mem_to_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: scoreboard of expected output-register contents.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_if #(.WIDTH(32), .PC_W(5), .REG_W(5)) bus ();
    ex_mem_stage #(.WIDTH(32), .PC_W(5), .REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [80:0] exp_q[$];
    logic [4:0]  seq = 5'd0;

    // {valid, pc, alu_res, write_data, jump_type, reg_we, mem_we, write_reg, mem_to_reg}
    function automatic logic [80:0] act_vec();
        return {bus.out_valid, bus.out_pc, bus.out_alu_res, bus.out_write_data,
                bus.out_jump_type, bus.out_reg_wrenable, bus.out_mem_wrenable,
                bus.out_write_reg, bus.out_mem_to_reg};
    endfunction

    function automatic logic [80:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.pc = '0; bus.alu_op = '0;
        bus.op_a = '0; bus.op_b = '0; bus.write_data = '0; bus.jump_type = '0;
        bus.reg_wrenable = 0; bus.mem_wrenable = 0; bus.write_reg = '0; bus.mem_to_reg = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] wr);
        seq = seq + 5'd1;
        bus.flush = 0; bus.in_valid = 1; bus.alu_op = op; bus.op_a = a; bus.op_b = b;
        bus.pc = seq; bus.write_data = {27'h0, seq} ^ 32'hA5A5_0000;
        bus.jump_type = seq[2:0]; bus.reg_wrenable = 1; bus.mem_wrenable = seq[0];
        bus.write_reg = wr; bus.mem_to_reg = seq[1];
        exp_q.push_back({1'b1, seq, res, {27'h0, seq} ^ 32'hA5A5_0000, seq[2:0],
                         1'b1, seq[0], wr, seq[1]});
    endtask

    task automatic test_reset();
        logic [80:0] e;
        idle_inputs();
        #12;
        n_tests++;
        if (act_vec() !== 81'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec());
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = 81'b0;
        n_tests++;
        if (act_vec() !== e) begin
            n_fail++; $display("FAIL idle_bubble: got %h want %h", act_vec(), e);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops[14]  = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd2, 4'd3, 4'd4,
                                  4'd5, 4'd6, 4'd11, 4'd0, 4'd15, 4'd13};
        logic [31:0] as[14]   = '{32'd7, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd1,
                                  32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'd5, 32'd9};
        logic [31:0] bs[14]   = '{32'd5, 32'd5, 32'd4, 32'd1, 32'd1, 32'hFF00_FF00,
                                  32'h0F0F_0000, 32'h0F0F_0F0F, 32'h23, 32'd31,
                                  32'hCAFE_BABE, 32'd2, 32'd5, 32'd3};
        logic [31:0] rs[14]   = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0,
                                  32'hF000_F000, 32'hFFFF_F0F0, 32'hF0F0_0F0F, 32'd8,
                                  32'd1, 32'hCAFE_BABE, 32'd1, 32'd0, 32'd0};
        logic [80:0] e;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            issue(ops[i], as[i], bs[i], rs[i], (i == 0) ? 5'd3 : 5'(i));
            @(negedge clk);
            e = pop_exp();
            n_tests++;
            if (act_vec() !== e) begin
                n_fail++;
                $display("FAIL alu_op%0d: got %h want %h", ops[i], act_vec(), e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
        logic [80:0] e;
        int bad_edge;
        @(negedge clk);
        issue(4'd10, a, b, a * b, 5'd7);
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul_accept: busy %b valid %b want 1 0", bus.busy, bus.out_valid);
        end
        bad_edge = -1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if ((bus.busy !== 1'b1 || bus.out_valid !== 1'b0) && bad_edge < 0) bad_edge = k;
        end
        n_tests++;
        if (bad_edge >= 0) begin
            n_fail++; $display("FAIL mul_busy_window: first bad edge %0d want none", bad_edge);
        end
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (act_vec() !== e || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result_%h_%h: got %h busy %b want %h busy 0", a, b, act_vec(), bus.busy, e);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        logic [80:0] e;
        @(negedge clk);
        issue(4'd0, 32'd1, 32'd1, 32'd2, 5'd9);
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (act_vec() !== e) begin
            n_fail++; $display("FAIL flush_pre: got %h want %h", act_vec(), e);
        end
        bus.flush = 1; bus.in_valid = 1; bus.alu_op = 4'd0; bus.op_a = 32'd4; bus.op_b = 32'd4;
        bus.mem_wrenable = 1; bus.jump_type = 3'b001; bus.reg_wrenable = 1; bus.write_reg = 5'd4;
        @(negedge clk);
        n_tests++;
        if (act_vec() !== 81'b0) begin
            n_fail++;
            $display("FAIL flush_bubble: got %h (mem_we %b jump %b) want 0",
                     act_vec(), bus.out_mem_wrenable, bus.out_jump_type);
        end
        idle_inputs();
    endtask

    task automatic test_mul_flush();
        logic [80:0] e;
        int stray;
        @(negedge clk);
        issue(4'd10, 32'd6, 32'd7, 32'd42, 5'd5);
        void'(exp_q.pop_back());
        @(negedge clk);
        for (int k = 1; k <= 9; k++) @(negedge clk);
        bus.flush = 1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || act_vec() !== 81'b0) begin
            n_fail++; $display("FAIL mul_abort: busy %b out %h want 0 0", bus.busy, act_vec());
        end
        issue(4'd0, 32'd20, 32'd22, 32'd42, 5'd6);
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (act_vec() !== e) begin
            n_fail++; $display("FAIL add_after_abort: got %h want %h", act_vec(), e);
        end
        idle_inputs();
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++; $display("FAIL no_result_after_abort: %0d valid/busy cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        logic [80:0] e;
        @(negedge clk);
        issue(4'd10, 32'd6, 32'd7, 32'd42, 5'd5);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (act_vec() !== 81'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_mul: out %h busy %b want 0 0", act_vec(), bus.busy);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd0, 32'd1, 32'd2, 32'd3, 5'd1);
        @(negedge clk);
        e = pop_exp();
        n_tests++;
        if (act_vec() !== e) begin
            n_fail++; $display("FAIL add_after_reset: got %h want %h", act_vec(), e);
        end
        issue(4'd0, 32'd5, 32'd6, 32'd11, 5'd2);
        void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (act_vec() !== 81'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_add: out %h busy %b want 0 0", act_vec(), bus.busy);
        end
        @(negedge clk);
        n_tests++;
        if (act_vec() !== 81'b0) begin
            n_fail++; $display("FAIL reset_held: out %h want 0", act_vec());
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [80:0] e;
        logic [31:0] a, b;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            issue(4'd0, a, b, a + b, 5'(i + 10));
            @(negedge clk);
            e = pop_exp();
            n_tests++;
            if (act_vec() !== e) begin
                n_fail++; $display("FAIL b2b_add%0d: got %h want %h", i, act_vec(), e);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul(32'd6, 32'd7);
        test_mul(32'hFFFF_FFFF, 32'd2);
        test_mul(32'h0001_2345, 32'h0000_6789);
        test_flush();
        test_mul_flush();
        test_reset_mid();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
